sr_ff_bank: RTL and testbench

- Parametrised bank of WIDTH clocked SR flip-flops; the synchronous, multi-channel successor to the single NOR SR latch.
- The response to S=R=1 is deterministic and selectable by parameter. Conflicts are detected, flagged per channel, and counted.
- Used wherever several independent set/clear status bits must be held, e.g. interrupt-pending bits and sticky error bits.

---
 rtl/sr_ff_bank.sv | 142 ++++++++++++++
 tb/tb_sr_ff_bank.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sr_ff_bank.sv
// sr_ff_bank: bank of WIDTH independent clocked SR flip-flops.
// The S=R=1 response is set by MODE. Each channel has a sticky conflict flag,
// and a shared saturating counter records the cycles with any conflict.
// Every output is registered, so there is no combinational path from input to output.
module sr_ff_bank #(
    parameter int              WIDTH   = 8,
    parameter int              MODE    = 0,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int              CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             flag_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] changed,
    output logic [WIDTH-1:0] conflict_flags,
    output logic [CNT_W-1:0] conflict_cnt
);

    // Refuse to elaborate with a channel count or mode that cannot be built.
    generate
        if (WIDTH < 1 || WIDTH > 32 || MODE < 0 || MODE > 4) begin : g_bad_param
            $error("sr_ff_bank: illegal parameter (WIDTH=%0d, MODE=%0d)", WIDTH, MODE);
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_qn;
    logic [WIDTH-1:0] r_changed;
    logic [WIDTH-1:0] r_flags;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_qn_next;
    logic [WIDTH-1:0] w_hit;
    logic [WIDTH-1:0] w_flags_next;
    logic             w_any_hit;
    logic [CNT_W-1:0] w_cnt_next;

    // A channel conflicts only when it is enabled and both requests are present.
    assign w_hit     = {WIDTH{en}} & s & r;
    assign w_any_hit = |w_hit;

    // Next state for each channel, worked out on its own.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_ch
            logic w_q_nx;
            logic w_qn_nx;

            // Per-channel SR next-state, including the MODE-specific S=R=1 resolution.
            always_comb begin
                w_q_nx  = r_q[gi];
                w_qn_nx = r_qn[gi];
                if (en && (s[gi] || r[gi])) begin
                    if (s[gi] && !r[gi]) begin
                        w_q_nx  = 1'b1;
                        w_qn_nx = 1'b0;
                    end else if (!s[gi] && r[gi]) begin
                        w_q_nx  = 1'b0;
                        w_qn_nx = 1'b1;
                    end else begin
                        if (MODE == 0) begin
                            // The NOR latch forces both outputs low while both requests are active.
                            w_q_nx  = 1'b0;
                            w_qn_nx = 1'b0;
                        end else if (MODE == 1) begin
                            w_q_nx  = 1'b1;
                            w_qn_nx = 1'b0;
                        end else if (MODE == 2) begin
                            w_q_nx  = 1'b0;
                            w_qn_nx = 1'b1;
                        end else if (MODE == 3) begin
                            w_q_nx  = ~r_q[gi];
                            w_qn_nx = r_q[gi];
                        end else begin
                            w_q_nx  = r_q[gi];
                            w_qn_nx = ~r_q[gi];
                        end
                    end
                end else if (!r_q[gi] && !r_qn[gi]) begin
                    // A channel left at q=qn=0 by a conflict settles to the reset state
                    // on the first edge with no request. This applies even when en=0,
                    // and q itself does not change.
                    w_qn_nx = 1'b1;
                end
            end

            assign w_q_next[gi]  = w_q_nx;
            assign w_qn_next[gi] = w_qn_nx;
        end
    endgenerate

    // Sticky flags: when a hit and flag_clr arrive together, the hit wins.
    always_comb begin
        w_flags_next = r_flags | w_hit;
        if (flag_clr) begin
            w_flags_next = w_hit;
        end
    end

    // Conflict counter: clears on flag_clr (reloads 1 on a simultaneous hit),
    // otherwise counts hit cycles and stops at the maximum instead of wrapping.
    always_comb begin
        w_cnt_next = r_cnt;
        if (flag_clr) begin
            w_cnt_next = w_any_hit ? CNT_W'(1) : '0;
        end else if (w_any_hit && (r_cnt != CNT_MAX)) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    // State registers. Reset is asynchronous and drops any pending update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q       <= RST_VAL;
            r_qn      <= ~RST_VAL;
            r_changed <= '0;
            r_flags   <= '0;
            r_cnt     <= '0;
        end else begin
            r_q       <= w_q_next;
            r_qn      <= w_qn_next;
            r_changed <= w_q_next ^ r_q;
            r_flags   <= w_flags_next;
            r_cnt     <= w_cnt_next;
        end
    end

    assign q              = r_q;
    assign qn             = r_qn;
    assign changed        = r_changed;
    assign conflict_flags = r_flags;
    assign conflict_cnt   = r_cnt;

endmodule

// File: tb/tb_sr_ff_bank.sv
// tb_sr_ff_bank: directed vectors with hand-computed expected values.
// One instance per MODE (0..4), all driven by the same stimulus.
module tb_sr_ff_bank;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] s;
    logic [3:0] r;
    logic       flag_clr;

    logic [3:0] q_w     [5];
    logic [3:0] qn_w    [5];
    logic [3:0] chg_w   [5];
    logic [3:0] flags_w [5];
    logic [2:0] cnt_w   [5];

    int vec_cnt;
    int err_cnt;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_dut
            sr_ff_bank #(
                .WIDTH   (4),
                .MODE    (gi),
                .RST_VAL (4'b0000),
                .CNT_W   (3)
            ) u_dut (
                .clk            (clk),
                .rst            (rst),
                .en             (en),
                .s              (s),
                .r              (r),
                .flag_clr       (flag_clr),
                .q              (q_w[gi]),
                .qn             (qn_w[gi]),
                .changed        (chg_w[gi]),
                .conflict_flags (flags_w[gi]),
                .conflict_cnt   (cnt_w[gi])
            );
        end
    endgenerate

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end else begin
            $display("ok   %s: %0h", tag, act);
        end
    endtask

    // Advance one clock and settle 1 ns past the edge before sampling.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_cnt  = 0;
        err_cnt  = 0;
        rst      = 1'b1;
        en       = 1'b0;
        s        = 4'b0000;
        r        = 4'b0000;
        flag_clr = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;

        // Plain set / reset / hold
        en = 1'b1; s = 4'b0101; r = 4'b0000; cyc();
        check("set_q",   q_w[1],   4'b0101);
        check("set_qn",  qn_w[1],  4'b1010);
        check("set_chg", chg_w[1], 4'b0101);
        s = 4'b0000; r = 4'b0100; cyc();
        check("rst_q",   q_w[1],   4'b0001);
        check("rst_qn",  qn_w[1],  4'b1110);
        check("rst_chg", chg_w[1], 4'b0100);
        s = 4'b0000; r = 4'b0000; cyc();
        check("hold_q",   q_w[1],   4'b0001);
        check("hold_chg", chg_w[1], 4'b0000);

        // Asynchronous reset in the middle of a cycle
        s = 4'b1010; r = 4'b0101; cyc();
        check("pre_rst_q",   q_w[4],   4'b1010);
        check("pre_rst_chg", chg_w[4], 4'b1011);
        s = 4'b0000; r = 4'b0000;
        #2 rst = 1'b1;
        #1;
        check("arst_q",     q_w[4],     4'b0000);
        check("arst_qn",    qn_w[4],    4'b1111);
        check("arst_chg",   chg_w[4],   4'b0000);
        check("arst_flags", flags_w[4], 4'b0000);
        check("arst_cnt",   cnt_w[4],   3'd0);
        #1 rst = 1'b0;

        // MODE 0 conflict on bit 0, followed by resolution
        s = 4'b0001; r = 4'b0001; cyc();
        check("m0_q",     q_w[0],     4'b0000);
        check("m0_qn",    qn_w[0],    4'b1110);
        check("m0_flags", flags_w[0], 4'b0001);
        check("m0_cnt",   cnt_w[0],   3'd1);
        s = 4'b0000; r = 4'b0000; cyc();
        check("m0_res_q",   q_w[0],   4'b0000);
        check("m0_res_qn",  qn_w[0],  4'b1111);
        check("m0_res_chg", chg_w[0], 4'b0000);

        // Bring every instance to q=0101, then apply an all-channel conflict
        s = 4'b0101; r = 4'b1010; cyc();
        check("m3_pre_q", q_w[3], 4'b0101);
        s = 4'b1111; r = 4'b1111; cyc();
        check("m0_all_q",  q_w[0],  4'b0000);
        check("m0_all_qn", qn_w[0], 4'b0000);
        check("m1_q",  q_w[1],  4'b1111);
        check("m1_qn", qn_w[1], 4'b0000);
        check("m2_q",  q_w[2],  4'b0000);
        check("m2_qn", qn_w[2], 4'b1111);
        check("m3_q",  q_w[3],  4'b1010);
        check("m3_qn", qn_w[3], 4'b0101);
        check("m4_q",  q_w[4],  4'b0101);
        check("m4_qn", qn_w[4], 4'b1010);
        for (int i = 1; i < 5; i++) begin
            check($sformatf("m%0d_flags", i), flags_w[i], 4'b1111);
        end
        cyc();
        check("m3_q2",  q_w[3],  4'b0101);
        check("m3_qn2", qn_w[3], 4'b1010);
        check("m1_cnt", cnt_w[1], 3'd3);

        // With en=0, nothing updates except MODE 0 settling its qn.
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check($sformatf("dis%0d_m1_q", i),   q_w[1],   4'b1111);
            check($sformatf("dis%0d_m3_chg", i), chg_w[3], 4'b0000);
            check($sformatf("dis%0d_m2_cnt", i), cnt_w[2], 3'd3);
        end
        check("dis_m1_qn",    qn_w[1],    4'b0000);
        check("dis_m1_flags", flags_w[1], 4'b1111);
        check("dis_m0_q",     q_w[0],     4'b0000);
        check("dis_m0_qn",    qn_w[0],    4'b1111);
        check("dis_m0_chg",   chg_w[0],   4'b0000);

        // Counter saturates at 7 and does not wrap.
        en = 1'b1; s = 4'b0001; r = 4'b0001;
        for (int i = 0; i < 9; i++) begin
            cyc();
            check($sformatf("sat%0d_cnt", i), cnt_w[2], (3 + i + 1 > 7) ? 32'd7 : 32'(3 + i + 1));
        end
        check("sat_m0_qn", qn_w[0], 4'b1110);

        // flag_clr on its own, then together with a hit
        s = 4'b0000; r = 4'b0000; flag_clr = 1'b1; cyc();
        check("clr_flags", flags_w[2], 4'b0000);
        check("clr_cnt",   cnt_w[2],   3'd0);
        check("clr_m0_qn", qn_w[0],    4'b1111);
        s = 4'b1000; r = 4'b1000; cyc();
        check("clrhit_flags", flags_w[2], 4'b1000);
        check("clrhit_cnt",   cnt_w[2],   3'd1);
        flag_clr = 1'b0; s = 4'b0000; r = 4'b0000; cyc();
        check("post_flags", flags_w[2], 4'b1000);
        check("post_cnt",   cnt_w[2],   3'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
